freq_counter_core: RTL and testbench

Measures the frequency of the single wave selected by the upstream 24-way input multiplexer. It synchronises the asynchronous selected wave into the system clock domain and counts its rising edges over a programmable gate window of system-clock cycles. It then holds the edge count for the controller under a valid/ack handshake. Frequency is computed downstream as edge_count × f_Clock / gate_len.

---
 rtl/freq_counter_pkg.sv | 22 ++
 rtl/freq_counter_core_if.sv | 34 +++
 rtl/freq_counter_core_edge_sync.sv | 39 +++
 rtl/freq_counter_core.sv | 153 +++++++++++++++
 tb/tb_freq_counter_core.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_counter_pkg
// Brief    : Shared state encoding and default sizing for freq_counter_core.
// Revision : 1.0 - initial release
// ============================================================================
package freq_counter_pkg;

    localparam int unsigned c_count_w       = 32;
    localparam int unsigned c_gate_w        = 32;
    localparam int unsigned c_sync_stages   = 2;
    localparam int unsigned c_settle_cycles = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/freq_counter_core_if.sv
`default_nettype none
// ============================================================================
// Module   : freq_counter_core_if
// Brief    : Control/result bundle between measurement controller and core.
// Revision : 1.0 - initial release
// ============================================================================
interface freq_counter_core_if
    import freq_counter_pkg::*;
#(
    parameter int unsigned COUNT_W = c_count_w,
    parameter int unsigned GATE_W  = c_gate_w
) ();

    logic               in_wave;
    logic               start;
    logic [GATE_W-1:0]  gate_len;
    logic               result_ack;
    logic               busy;
    logic               result_valid;
    logic [COUNT_W-1:0] edge_count;
    logic               overflow;

    modport master (
        output in_wave, start, gate_len, result_ack,
        input  busy, result_valid, edge_count, overflow
    );

    modport slave (
        input  in_wave, start, gate_len, result_ack,
        output busy, result_valid, edge_count, overflow
    );

endinterface
`default_nettype wire

// File: rtl/freq_counter_core_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : edge_sync
// Brief    : Synchroniser chain plus registered rising-edge pulse generator.
// Revision : 1.0 - initial release
// ============================================================================
module edge_sync
    import freq_counter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = c_sync_stages
) (
    input  wire logic Clock,
    input  wire logic Reset,
    input  wire logic i_wave,
    output logic      o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;

    // r_prev tracks the synchronised level every cycle so a level that is
    // already high when a window opens never looks like a fresh edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_wave};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/freq_counter_core.sv
`default_nettype none
// ============================================================================
// Module   : freq_counter_core
// Brief    : Counts synchronised rising edges over a gate window and holds
//            the result under a valid/ack handshake.
//            Optional settle phase: define FREQ_COUNTER_SETTLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module freq_counter_core
    import freq_counter_pkg::*;
#(
    parameter int unsigned COUNT_W       = c_count_w,
    parameter int unsigned GATE_W        = c_gate_w,
    parameter int unsigned SYNC_STAGES   = c_sync_stages,
    parameter int unsigned SETTLE_CYCLES = c_settle_cycles
) (
    input  wire logic          Clock,
    input  wire logic          Reset,
    freq_counter_core_if.slave bus
);

    localparam logic [COUNT_W-1:0] c_count_max = '1;
`ifdef FREQ_COUNTER_SETTLE_EN
    localparam state_t c_first_state = ST_ARM;
`else
    localparam state_t c_first_state = ST_COUNT;
`endif

    state_t              r_state;
    state_t              w_state_next;
    logic [GATE_W-1:0]   r_timer;
    logic [GATE_W-1:0]   w_gate_eff;
    logic [COUNT_W-1:0]  r_count;
    logic [COUNT_W-1:0]  w_count_next;
    logic [COUNT_W-1:0]  r_edge_count;
    logic                r_ovf;
    logic                w_ovf_next;
    logic                r_overflow;
    logic                w_pulse;
    logic                w_start_accept;
    logic                w_timer_zero;
`ifdef FREQ_COUNTER_SETTLE_EN
    logic [GATE_W-1:0]   r_gate_len;
`endif

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_wave  (bus.in_wave),
        .o_pulse (w_pulse)
    );

    assign w_gate_eff   = (bus.gate_len == '0) ? GATE_W'(1) : bus.gate_len;
    assign w_timer_zero = (r_timer == '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_start_accept = 1'b0;
        w_count_next   = r_count;
        w_ovf_next     = r_ovf;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_start_accept = 1'b1;
                    w_state_next   = c_first_state;
                end
            end
`ifdef FREQ_COUNTER_SETTLE_EN
            ST_ARM: begin
                if (w_timer_zero) begin
                    w_state_next = ST_COUNT;
                end
            end
`endif
            ST_COUNT: begin
                if (w_pulse) begin
                    if (r_count == c_count_max) begin
                        w_ovf_next = 1'b1;
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end
                if (w_timer_zero) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // A new request takes precedence over a simultaneous ack.
                if (bus.start) begin
                    w_start_accept = 1'b1;
                    w_state_next   = c_first_state;
                end else if (bus.result_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_timer      <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_edge_count <= '0;
            r_overflow   <= 1'b0;
`ifdef FREQ_COUNTER_SETTLE_EN
            r_gate_len   <= '0;
`endif
        end else if (w_start_accept) begin
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_edge_count <= '0;
            r_overflow   <= 1'b0;
`ifdef FREQ_COUNTER_SETTLE_EN
            r_gate_len   <= w_gate_eff;
            r_timer      <= GATE_W'(SETTLE_CYCLES - 1);
        end else if (r_state == ST_ARM) begin
            r_timer <= w_timer_zero ? (r_gate_len - 1'b1) : (r_timer - 1'b1);
`else
            r_timer      <= w_gate_eff - 1'b1;
`endif
        end else if (r_state == ST_COUNT) begin
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            if (w_timer_zero) begin
                r_edge_count <= w_count_next;
                r_overflow   <= w_ovf_next;
            end else begin
                r_timer <= r_timer - 1'b1;
            end
        end
    end

    assign bus.busy         = (r_state == ST_ARM) || (r_state == ST_COUNT);
    assign bus.result_valid = (r_state == ST_DONE);
    assign bus.edge_count   = r_edge_count;
    assign bus.overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_freq_counter_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_counter_core
// Brief    : Scoreboard bench for freq_counter_core (32-bit and 4-bit counter
//            instances). Honours FREQ_COUNTER_SETTLE_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_counter_core;
    import freq_counter_pkg::*;

    localparam int c_sync    = 2;
    localparam int c_timeout = 5000;
`ifdef FREQ_COUNTER_SETTLE_EN
    localparam int c_arm = 16;
`else
    localparam int c_arm = 0;
`endif

    typedef struct {
        int unsigned cnt;
        logic        ovf;
        int          vcyc;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   wp_a  = 0;
    int   wh_a  = 0;
    int   wp_b  = 0;
    int   wh_b  = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    freq_counter_core_if #(.COUNT_W(32), .GATE_W(32)) bus_a ();
    freq_counter_core_if #(.COUNT_W(4),  .GATE_W(16)) bus_b ();

    freq_counter_core #(
        .COUNT_W(32), .GATE_W(32), .SYNC_STAGES(c_sync), .SETTLE_CYCLES(16)
    ) u_dut_a (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_a)
    );

    freq_counter_core #(
        .COUNT_W(4), .GATE_W(16), .SYNC_STAGES(c_sync), .SETTLE_CYCLES(16)
    ) u_dut_b (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_b)
    );

    always #5 Clock = ~Clock;

    // Wave level during cycle k; period 0 means a constant level h!=0.
    function automatic logic wfun(int k, int p, int h);
        if (p == 0) return (h != 0);
        return ((k % p) < h);
    endfunction

    // Rising edge first high in cycle k yields a counted pulse in k+sync+1.
    function automatic int model_edges(int c0, int g, int p, int h);
        int n = 0;
        int geff = (g == 0) ? 1 : g;
        for (int pc = c0 + c_arm + 1; pc <= c0 + c_arm + geff; pc++) begin
            if (wfun(pc - c_sync - 1, p, h) && !wfun(pc - c_sync - 2, p, h)) n++;
        end
        return n;
    endfunction

    initial begin
        forever begin
            @(posedge Clock);
            cyc++;
            #1;
            bus_a.in_wave = wfun(cyc, wp_a, wh_a);
            bus_b.in_wave = wfun(cyc, wp_b, wh_b);
        end
    end

    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic start_a(int g, logic ack);
        exp_t e;
        int   geff;
        geff   = (g == 0) ? 1 : g;
        e.cnt  = model_edges(cyc, g, wp_a, wh_a);
        e.ovf  = 1'b0;
        e.vcyc = cyc + c_arm + geff + 1;
        q_a.push_back(e);
        bus_a.start      = 1'b1;
        bus_a.result_ack = ack;
        bus_a.gate_len   = 32'(g);
        tick();
        bus_a.start      = 1'b0;
        bus_a.result_ack = 1'b0;
        bus_a.gate_len   = 32'd7;
    endtask

    task automatic ack_a();
        bus_a.result_ack = 1'b1;
        tick();
        bus_a.result_ack = 1'b0;
    endtask

    task automatic wait_valid_a(output bit ok);
        int n = 0;
        while (bus_a.result_valid !== 1'b1 && n < c_timeout) begin
            tick();
            n++;
        end
        ok = (bus_a.result_valid === 1'b1);
    endtask

    task automatic set_wave_a(int p, int h);
        wp_a = p;
        wh_a = h;
        tick(6);
    endtask

    task automatic test_reset();
        tick(3);
        n_vec += 6;
        if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus_a.busy); end
        if (bus_a.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus_a.result_valid); end
        if (bus_a.edge_count !== 32'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus_a.edge_count); end
        if (bus_a.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", bus_a.overflow); end
        if (bus_b.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_b got %b want 0", bus_b.result_valid); end
        if (bus_b.edge_count !== 4'd0) begin n_err++; $display("FAIL reset_count_b got %0d want 0", bus_b.edge_count); end
        Reset = 1'b0;
        tick();
    endtask

    // Runs one window on instance A and checks timing, count and overflow.
    task automatic test_window(string name, int p, int h, int g);
        exp_t e;
        bit   ok;
        set_wave_a(p, h);
        start_a(g, 1'b0);
        n_vec += 2;
        if (bus_a.busy !== 1'b1) begin n_err++; $display("FAIL %s_busy got %b want 1", name, bus_a.busy); end
        if (bus_a.edge_count !== 32'd0) begin n_err++; $display("FAIL %s_cleared got %0d want 0", name, bus_a.edge_count); end
        wait_valid_a(ok);
        e = q_a.pop_front();
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_timeout got valid=%b want 1", name, bus_a.result_valid);
        end else begin
            n_vec += 3;
            if (cyc !== e.vcyc) begin n_err++; $display("FAIL %s_latency got cycle %0d want %0d", name, cyc, e.vcyc); end
            if (bus_a.edge_count !== e.cnt) begin n_err++; $display("FAIL %s_count got %0d want %0d", name, bus_a.edge_count, e.cnt); end
            if (bus_a.overflow !== e.ovf) begin n_err++; $display("FAIL %s_ovf got %b want %b", name, bus_a.overflow, e.ovf); end
        end
        tick(3);
        n_vec++;
        if (bus_a.result_valid !== 1'b1) begin n_err++; $display("FAIL %s_hold got %b want 1", name, bus_a.result_valid); end
        ack_a();
        n_vec += 2;
        if (bus_a.result_valid !== 1'b0) begin n_err++; $display("FAIL %s_ack_valid got %b want 0", name, bus_a.result_valid); end
        if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL %s_ack_busy got %b want 0", name, bus_a.busy); end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        bit   ok;
        set_wave_a(10, 5);
        start_a(40, 1'b0);
        tick(10);
        bus_a.start    = 1'b1;
        bus_a.gate_len = 32'd5;
        tick();
        bus_a.start    = 1'b0;
        wait_valid_a(ok);
        e = q_a.pop_front();
        n_vec++;
        if (!ok || cyc !== e.vcyc || bus_a.edge_count !== e.cnt) begin
            n_err++;
            $display("FAIL ignore_start got cycle %0d count %0d want cycle %0d count %0d", cyc, bus_a.edge_count, e.vcyc, e.cnt);
        end
        ack_a();
    endtask

    task automatic test_reset_mid();
        set_wave_a(10, 5);
        start_a(1000, 1'b0);
        tick(50);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        q_a.delete();
        n_vec += 3;
        if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", bus_a.busy); end
        if (bus_a.result_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", bus_a.result_valid); end
        if (bus_a.edge_count !== 32'd0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", bus_a.edge_count); end
        test_window("after_rst", 10, 5, 200);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        set_wave_a(10, 5);
        start_a(30, 1'b0);
        wait_valid_a(ok);
        e = q_a.pop_front();
        n_vec++;
        if (!ok || bus_a.edge_count !== e.cnt) begin
            n_err++;
            $display("FAIL b2b_first got count %0d want %0d", bus_a.edge_count, e.cnt);
        end
        start_a(60, 1'b1);
        n_vec += 3;
        if (bus_a.result_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid got %b want 0", bus_a.result_valid); end
        if (bus_a.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", bus_a.busy); end
        if (bus_a.edge_count !== 32'd0) begin n_err++; $display("FAIL b2b_cleared got %0d want 0", bus_a.edge_count); end
        wait_valid_a(ok);
        e = q_a.pop_front();
        n_vec++;
        if (!ok || cyc !== e.vcyc || bus_a.edge_count !== e.cnt) begin
            n_err++;
            $display("FAIL b2b_second got cycle %0d count %0d want cycle %0d count %0d", cyc, bus_a.edge_count, e.vcyc, e.cnt);
        end
        ack_a();
    endtask

    task automatic test_saturate();
        exp_t e;
        int   n;
        int   w;
        wp_b = 4;
        wh_b = 2;
        tick(6);
        n      = model_edges(cyc, 100, wp_b, wh_b);
        e.cnt  = (n > 15) ? 15 : n;
        e.ovf  = (n > 15);
        e.vcyc = cyc + c_arm + 101;
        q_b.push_back(e);
        bus_b.start    = 1'b1;
        bus_b.gate_len = 16'd100;
        tick();
        bus_b.start    = 1'b0;
        w = 0;
        while (bus_b.result_valid !== 1'b1 && w < c_timeout) begin
            tick();
            w++;
        end
        e = q_b.pop_front();
        n_vec += 3;
        if (cyc !== e.vcyc) begin n_err++; $display("FAIL sat_latency got cycle %0d want %0d", cyc, e.vcyc); end
        if (bus_b.edge_count !== 4'(e.cnt)) begin n_err++; $display("FAIL sat_count got %0d want %0d", bus_b.edge_count, e.cnt); end
        if (bus_b.overflow !== e.ovf) begin n_err++; $display("FAIL sat_ovf got %b want %b", bus_b.overflow, e.ovf); end
        bus_b.result_ack = 1'b1;
        tick();
        bus_b.result_ack = 1'b0;
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.result_ack = 1'b0; bus_a.gate_len = '0; bus_a.in_wave = 1'b0;
        bus_b.start = 1'b0; bus_b.result_ack = 1'b0; bus_b.gate_len = '0; bus_b.in_wave = 1'b0;
        test_reset();
        test_window("basic", 10, 5, 1000);
        test_window("fast", 2, 1, 50);
        test_window("gate_zero", 0, 1, 0);
        test_window("gate_one_edge", 3, 1, 1);
        test_ignore_start();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
